// File: rtl/prog_clk_div.sv
// prog_clk_div: NCH independent programmable clock dividers on one clock.
// Each channel counts up to its active half-period and then toggles its
// square-wave output. A tick strobe marks each rising edge of the output.
// New half-period values are staged as pending and take effect only at a
// terminal count, so no output half-period is ever cut short.
// Optional feature: define PROG_CLK_DIV_SYNC_EN to add the 'sync' input.
// A sync pulse restarts every enabled channel in phase and applies any
// pending value immediately.
module prog_clk_div #(
  parameter int NCH          = 4,
  parameter int CW           = 19,
  parameter int DEFAULT_HALF = 499999,
  parameter int CHW          = 2
) (
  input  logic            clk_in,
  input  logic            rst,
`ifdef PROG_CLK_DIV_SYNC_EN
  input  logic            sync,
`endif
  input  logic [NCH-1:0]  en,
  input  logic            cfg_we,
  input  logic [CHW-1:0]  cfg_ch,
  input  logic [CW-1:0]   cfg_half,
  output logic [NCH-1:0]  cfg_pending,
  output logic [NCH-1:0]  clk_out,
  output logic [NCH-1:0]  tick
);

  localparam logic [CW-1:0] RESET_HALF = CW'(DEFAULT_HALF);

  logic [CW-1:0]  count_q     [NCH];
  logic [CW-1:0]  count_d     [NCH];
  logic [CW-1:0]  act_half_q  [NCH];
  logic [CW-1:0]  act_half_d  [NCH];
  logic [CW-1:0]  pend_half_q [NCH];
  logic [CW-1:0]  pend_half_d [NCH];
  logic [NCH-1:0] pending_q, pending_d;
  logic [NCH-1:0] clk_out_q, clk_out_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] wr_hit;
  logic [NCH-1:0] terminal;

  // Decode which channel a write targets and which channels hit terminal count.
  // A select value at or above NCH matches no channel, so that write is dropped.
  always_comb begin
    wr_hit   = '0;
    terminal = '0;
    for (int n = 0; n < NCH; n++) begin
      wr_hit[n]   = cfg_we && (cfg_ch == CHW'(n));
      terminal[n] = en[n] && (count_q[n] == act_half_q[n]);
    end
  end

  // Compute each channel's next counter, output, strobe and staged config.
  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      count_d[n]     = count_q[n];
      act_half_d[n]  = act_half_q[n];
      pend_half_d[n] = pend_half_q[n];
      pending_d[n]   = pending_q[n];
      clk_out_d[n]   = clk_out_q[n];
      tick_d[n]      = 1'b0;

      if (terminal[n]) begin
        count_d[n]   = '0;
        clk_out_d[n] = ~clk_out_q[n];
        tick_d[n]    = ~clk_out_q[n];
        if (pending_q[n]) begin
          act_half_d[n] = pend_half_q[n];
          pending_d[n]  = 1'b0;
        end
      end else if (en[n]) begin
        count_d[n] = count_q[n] + CW'(1);
      end

`ifdef PROG_CLK_DIV_SYNC_EN
      if (sync && en[n]) begin
        count_d[n]   = '0;
        clk_out_d[n] = 1'b0;
        tick_d[n]    = 1'b0;
        if (pending_q[n]) begin
          act_half_d[n] = pend_half_q[n];
          pending_d[n]  = 1'b0;
        end
      end
`endif

      // A write is evaluated last. A write that lands on a boundary therefore
      // stays pending for the next boundary instead of being applied now.
      if (wr_hit[n]) begin
        pend_half_d[n] = cfg_half;
        pending_d[n]   = 1'b1;
      end
    end
  end

  // Register all channel state; reset restores the default half-period everywhere.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int n = 0; n < NCH; n++) begin
        count_q[n]     <= '0;
        act_half_q[n]  <= RESET_HALF;
        pend_half_q[n] <= RESET_HALF;
      end
      pending_q <= '0;
      clk_out_q <= '0;
      tick_q    <= '0;
    end else begin
      count_q     <= count_d;
      act_half_q  <= act_half_d;
      pend_half_q <= pend_half_d;
      pending_q   <= pending_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
    end
  end

  assign cfg_pending = pending_q;
  assign clk_out     = clk_out_q;
  assign tick        = tick_q;

endmodule

// File: doc/prog_clk_div.md
PROG_CLK_DIV -- requirements
Module: prog_clk_div

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent divider channels (1..8).
REQ-002 SHALL have parameter CW, default 19, counter and half-period width in bits.
REQ-003 SHALL have parameter DEFAULT_HALF, default 499999, reset half-period-minus-one for every channel (100 Hz from 100 MHz).
REQ-004 SHALL have parameter CHW, default 2, channel-select width; NCH <= 2**CHW.
REQ-005 SHALL have port clk_in  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port en  input  NCH  per-channel run enable.
REQ-008 SHALL have port cfg_we  input  1  one-cycle write strobe for a new half-period.
REQ-009 SHALL have port cfg_ch  input  CHW  target channel of the write.
REQ-010 SHALL have port cfg_half  input  CW  new half-period-minus-one value.
REQ-011 SHALL have port cfg_pending  output  NCH  bit n high while channel n holds an unapplied write.
REQ-012 SHALL have port clk_out  output  NCH  per-channel square-wave output, registered.
REQ-013 SHALL have port tick  output  NCH  one-cycle strobe per output period, registered.

Function
REQ-014 Each channel SHALL keep count[CW-1:0], active half-period act_half, pending value pend_half and a pending flag.
REQ-015 While en[n]=1 and count!=act_half, count SHALL increment by 1 each cycle.
REQ-016 While en[n]=1 and count==act_half (terminal count), count SHALL go to 0 and clk_out[n] SHALL toggle in the same cycle.
REQ-017 Output period SHALL be 2*(act_half+1) cycles; act_half=0 SHALL give divide-by-2 with clk_out toggling every cycle.
REQ-018 tick[n] SHALL be high for exactly one cycle, the cycle in which clk_out[n] goes 0->1; otherwise 0.
REQ-019 While en[n]=0, count and clk_out[n] SHALL hold, tick[n] SHALL be 0, and no pending value SHALL be applied.
REQ-020 A write (cfg_we=1, cfg_ch<NCH) SHALL capture cfg_half into pend_half of channel cfg_ch and set its pending flag on the next edge.
REQ-021 A write with cfg_ch>=NCH SHALL be ignored with no state change.
REQ-022 A second write before application SHALL overwrite pend_half; only the last value is applied.
REQ-023 At a terminal count with pending set, act_half SHALL load pend_half and pending SHALL clear; the count restarts from 0 under the new value, so no output half-period is truncated (glitch-free change).
REQ-024 A write in the same cycle as a terminal count SHALL NOT be applied at that boundary: the previously pending value (if any) is applied, and the new value stays pending until the next terminal count.
REQ-025 cfg_pending[n] SHALL equal the pending flag of channel n.
REQ-026 Channels SHALL be fully independent; writes to one channel SHALL not alter timing of others.

Reset
REQ-027 On rst=1 at a clk_in edge: count=0, act_half=DEFAULT_HALF, pend_half=DEFAULT_HALF, pending=0, clk_out=0, tick=0 for all channels.
REQ-028 rst SHALL dominate en, cfg_we and sync; a reset mid-period discards the partial count and any pending write.
REQ-029 The first terminal count after reset SHALL occur DEFAULT_HALF+1 enabled cycles after rst deasserts, raising clk_out and tick.

Configuration
REQ-030 Macro PROG_CLK_DIV_SYNC_EN SHALL, when defined, add port sync  input  1: on sync=1 every channel with en=1 SHALL set count=0, clk_out=0, tick=0, and apply any pending value immediately (pending clears).
REQ-031 sync SHALL take priority over terminal count and write capture in the same cycle, but a simultaneous write SHALL still be captured as pending.
REQ-032 Without PROG_CLK_DIV_SYNC_EN the sync port and its logic SHALL be absent; behaviour otherwise identical.

Verification (NCH=4, CW=8, DEFAULT_HALF=4)
REQ-033 Reset, en=4'hF -> all clk_out rise together 5 cycles after reset release, period 10 cycles, one tick per period.
REQ-034 Write ch1 cfg_half=1 mid-period -> cfg_pending[1]=1 until ch1 terminal count; subsequent ch1 period 4 cycles, no short pulse; ch0/2/3 unchanged.
REQ-035 Write ch2 cfg_half=0 -> after application clk_out[2] toggles every cycle, tick[2] every 2 cycles.
REQ-036 Write ch0 values 3 then 6 before its terminal count -> only 6 applied, period 14; write on exact terminal-count cycle -> applied one half-period later.
REQ-037 Drop en[3] for 7 cycles mid-count -> clk_out[3] and count frozen, tick[3]=0; resumes exactly where stopped; cfg_ch=3'd... out-of-range write (CHW=3 build, cfg_ch=5) -> no change.
REQ-038 With PROG_CLK_DIV_SYNC_EN: pulse sync with differing phases and a pending ch1 value -> all enabled clk_out=0 next cycle, ch1 on new period, all rise in phase per their half-periods; rst asserted mid-period -> REQ-027 values next cycle.
